// File: rtl/fetch_hazard_ctrl_pkg.sv
// Shared constants and control-bundle type for the fetch/pipeline hazard sequencer.
// State codes match the legacy FHC_* encoding used elsewhere in the core.
package fetch_hazard_ctrl_pkg;

  localparam logic [1:0] FHC_BOOT     = 2'd0;
  localparam logic [1:0] FHC_RUN      = 2'd1;
  localparam logic [1:0] FHC_REDIRECT = 2'd2;
  localparam logic [1:0] FHC_HALT     = 2'd3;

  localparam int PERF_CNT_W  = 32;
  localparam int REDIR_CNT_W = 16;
  localparam int BOOT_CNT_W  = 4;

  typedef struct packed {
    logic pc_wr_en;
    logic if_id_wr_en;
    logic if_id_flush;
    logic id_ex_wr_en;
    logic id_ex_flush;
    logic fetch_valid;
    logic halted;
  } ctrl_t;

  // Free-running pipeline: everything advances, nothing is squashed.
  function automatic ctrl_t ctrl_advance();
    ctrl_t c;
    c.pc_wr_en    = 1'b1;
    c.if_id_wr_en = 1'b1;
    c.if_id_flush = 1'b0;
    c.id_ex_wr_en = 1'b1;
    c.id_ex_flush = 1'b0;
    c.fetch_valid = 1'b1;
    c.halted      = 1'b0;
    return c;
  endfunction

  function automatic ctrl_t ctrl_squash_all();
    ctrl_t c;
    c.pc_wr_en    = 1'b0;
    c.if_id_wr_en = 1'b0;
    c.if_id_flush = 1'b1;
    c.id_ex_wr_en = 1'b0;
    c.id_ex_flush = 1'b1;
    c.fetch_valid = 1'b0;
    c.halted      = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/fetch_hazard_ctrl_sat_counter.sv
// Up-counter with synchronous clear; SATURATE selects sticking at all-ones versus wrapping.
module sat_counter
  #(parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b1)
  (input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count);

  logic at_max;

  assign at_max = (count == {WIDTH{1'b1}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !(SATURATE && at_max)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Front-end sequencer: arbitrates redirects, EX stalls, load-use bubbles and halt,
// driving the fetch stage and the IF/ID, ID/EX register controls combinationally.
module fetch_hazard_ctrl
  import fetch_hazard_ctrl_pkg::*;
  #(parameter int BOOT_CYCLES = 1,
    parameter int ADDR_W      = 32)
  (input  logic                   clk,
   input  logic                   rst,
   input  logic                   branch_taken,
   input  logic [ADDR_W-1:0]      branch_target,
   input  logic                   ex_busy,
   input  logic                   load_use_hazard,
   input  logic                   halt_req,
   input  logic                   resume,
   output logic                   pc_wr_en,
   output logic                   jump_enable,
   output logic [ADDR_W-1:0]      jump_address,
   output logic                   if_id_wr_en,
   output logic                   if_id_flush,
   output logic                   id_ex_wr_en,
   output logic                   id_ex_flush,
   output logic                   fetch_valid,
   output logic                   halted,
   output logic [PERF_CNT_W-1:0]  stall_cycles,
   output logic [REDIR_CNT_W-1:0] redirect_count);

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic [BOOT_CNT_W-1:0] boot_cnt_q;
  ctrl_t                 ctrl;
  logic                  stall_inc;
  logic                  redirect_inc;
  logic                  in_boot;

  assign in_boot = (state_q == FHC_BOOT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FHC_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      boot_cnt_q <= BOOT_CNT_W'(BOOT_CYCLES);
    end else if (in_boot && boot_cnt_q != '0) begin
      boot_cnt_q <= boot_cnt_q - 1'b1;
    end
  end

  // Leave BOOT on the cycle whose decrement takes the counter to zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FHC_BOOT: begin
        if (boot_cnt_q <= BOOT_CNT_W'(1)) state_d = FHC_RUN;
      end
      FHC_RUN: begin
        if (branch_taken)  state_d = FHC_REDIRECT;
        else if (halt_req) state_d = FHC_HALT;
      end
      FHC_REDIRECT: begin
        if (!ex_busy) state_d = FHC_RUN;
      end
      FHC_HALT: begin
        if (resume) state_d = FHC_REDIRECT;
      end
      default: state_d = FHC_BOOT;
    endcase
  end

  // RUN starts from the free-running bundle and each request overrides only what it must.
  always_comb begin
    ctrl         = ctrl_squash_all();
    jump_enable  = 1'b0;
    jump_address = '0;
    case (state_q)
      FHC_RUN: begin
        ctrl = ctrl_advance();
        if (branch_taken) begin
          jump_enable      = 1'b1;
          jump_address     = branch_target;
          ctrl.if_id_flush = 1'b1;
          ctrl.id_ex_flush = 1'b1;
        end else if (halt_req) begin
          ctrl.pc_wr_en    = 1'b0;
          ctrl.if_id_flush = 1'b1;
        end else if (ex_busy) begin
          ctrl.pc_wr_en    = 1'b0;
          ctrl.if_id_wr_en = 1'b0;
          ctrl.id_ex_wr_en = 1'b0;
        end else if (load_use_hazard) begin
          ctrl.pc_wr_en    = 1'b0;
          ctrl.if_id_wr_en = 1'b0;
          ctrl.id_ex_flush = 1'b1;
        end
      end
      FHC_REDIRECT: begin
        ctrl.id_ex_flush = 1'b0;
        if (!ex_busy) begin
          ctrl.pc_wr_en    = 1'b1;
          ctrl.id_ex_wr_en = 1'b1;
        end
      end
      FHC_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: begin
        ctrl = ctrl_squash_all();
      end
    endcase
  end

  assign pc_wr_en    = ctrl.pc_wr_en;
  assign if_id_wr_en = ctrl.if_id_wr_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_wr_en = ctrl.id_ex_wr_en;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign fetch_valid = ctrl.fetch_valid;
  assign halted      = ctrl.halted;

  assign stall_inc    = (state_q == FHC_RUN) && !ctrl.pc_wr_en;
  assign redirect_inc = (state_q == FHC_RUN) && branch_taken;

  sat_counter #(.WIDTH(PERF_CNT_W), .SATURATE(1'b1)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .clear (in_boot),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(REDIR_CNT_W), .SATURATE(1'b0)) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect_inc),
    .clear (in_boot),
    .count (redirect_count)
  );

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Scoreboard bench for fetch_hazard_ctrl: a reference model pushes expectations per cycle,
// which are popped and compared against the DUT outputs mid-cycle.
module tb_fetch_hazard_ctrl;

  localparam int BOOT   = 3;
  localparam int ADDR_W = 32;
  localparam int S_BOOT = 0, S_RUN = 1, S_REDIR = 2, S_HALT = 3;

  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] stall;
    logic [15:0] redir;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic branch_taken = 1'b0;
  logic [ADDR_W-1:0] branch_target = '0;
  logic ex_busy = 1'b0, load_use_hazard = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic pc_wr_en, jump_enable, if_id_wr_en, if_id_flush, id_ex_wr_en, id_ex_flush;
  logic fetch_valid, halted;
  logic [ADDR_W-1:0] jump_address;
  logic [31:0] stall_cycles;
  logic [15:0] redirect_count;

  logic sat_inc = 1'b0, sat_clr = 1'b0;
  logic [3:0] sat_cnt, wrap_cnt;

  int errors = 0;
  int checks = 0;
  int m_state;
  int m_boot;
  logic [31:0] m_stall;
  logic [15:0] m_redir;
  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_hazard_ctrl #(.BOOT_CYCLES(BOOT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .ex_busy(ex_busy), .load_use_hazard(load_use_hazard),
    .halt_req(halt_req), .resume(resume),
    .pc_wr_en(pc_wr_en), .jump_enable(jump_enable), .jump_address(jump_address),
    .if_id_wr_en(if_id_wr_en), .if_id_flush(if_id_flush),
    .id_ex_wr_en(id_ex_wr_en), .id_ex_flush(id_ex_flush),
    .fetch_valid(fetch_valid), .halted(halted),
    .stall_cycles(stall_cycles), .redirect_count(redirect_count)
  );

  sat_counter #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .inc(sat_inc), .clear(sat_clr), .count(sat_cnt));

  sat_counter #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .inc(sat_inc), .clear(sat_clr), .count(wrap_cnt));

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // ctrl packing: {pc_wr_en, if_id_wr_en, if_id_flush, id_ex_wr_en, id_ex_flush, fetch_valid, halted, jump_enable}
  function automatic exp_t model_outputs();
    exp_t e;
    e.ctrl  = 8'b0_0_1_0_1_0_0_0;
    e.addr  = '0;
    e.stall = m_stall;
    e.redir = m_redir;
    case (m_state)
      S_RUN: begin
        if (branch_taken) begin
          e.ctrl = 8'b1_1_1_1_1_1_0_1;
          e.addr = branch_target;
        end else if (halt_req)        e.ctrl = 8'b0_1_1_1_0_1_0_0;
        else if (ex_busy)             e.ctrl = 8'b0_0_0_0_0_1_0_0;
        else if (load_use_hazard)     e.ctrl = 8'b0_0_0_1_1_1_0_0;
        else                          e.ctrl = 8'b1_1_0_1_0_1_0_0;
      end
      S_REDIR: e.ctrl = ex_busy ? 8'b0_0_1_0_0_0_0_0 : 8'b1_0_1_1_0_0_0_0;
      S_HALT:  e.ctrl = 8'b0_0_1_0_1_0_1_0;
      default: e.ctrl = 8'b0_0_1_0_1_0_0_0;
    endcase
    return e;
  endfunction

  task automatic model_advance();
    if (!rst) return;
    case (m_state)
      S_BOOT: begin
        m_boot--;
        if (m_boot == 0) m_state = S_RUN;
      end
      S_RUN: begin
        if (!branch_taken && (halt_req || ex_busy || load_use_hazard) && m_stall != 32'hFFFF_FFFF)
          m_stall++;
        if (branch_taken) begin
          m_redir++;
          m_state = S_REDIR;
        end else if (halt_req) begin
          m_state = S_HALT;
        end
      end
      S_REDIR: if (!ex_busy) m_state = S_RUN;
      S_HALT:  if (resume) m_state = S_REDIR;
      default: m_state = S_BOOT;
    endcase
  endtask

  task automatic applyStimulus(input logic r, input logic bt, input logic [31:0] tgt,
                               input logic busy, input logic lu, input logic hr, input logic rs);
    exp_t e;
    rst = r; branch_taken = bt; branch_target = tgt;
    ex_busy = busy; load_use_hazard = lu; halt_req = hr; resume = rs;
    if (!r) begin
      m_state = S_BOOT; m_boot = BOOT; m_stall = '0; m_redir = '0;
    end
    sb.push_back(model_outputs());
    #2;
    e = sb.pop_front();
    checkOutput("ctrl", {pc_wr_en, if_id_wr_en, if_id_flush, id_ex_wr_en, id_ex_flush,
                         fetch_valid, halted, jump_enable}, e.ctrl);
    checkOutput("jump_address", jump_address, e.addr);
    checkOutput("stall_cycles", stall_cycles, e.stall);
    checkOutput("redirect_count", redirect_count, e.redir);
    model_advance();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 32'h0, 0, 0, 0, 0);
  endtask

  initial begin
    applyStimulus(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 1, 1, 1, 1);
    idle(3);
    idle(2);
    applyStimulus(1, 1, 32'h0000_0100, 0, 0, 0, 0);
    idle(2);
    applyStimulus(1, 0, 32'h0, 0, 1, 0, 0);
    idle(1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 32'h0, 1, 0, 0, 0);
    idle(1);
    applyStimulus(1, 1, 32'h0000_0200, 0, 1, 1, 0);
    applyStimulus(1, 0, 32'h0, 1, 0, 0, 0);
    applyStimulus(1, 0, 32'h0, 1, 0, 0, 0);
    idle(2);
    applyStimulus(1, 0, 32'h0, 0, 0, 1, 0);
    applyStimulus(1, 1, 32'h0000_0300, 1, 1, 1, 0);
    idle(1);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 1);
    idle(2);
    applyStimulus(1, 0, 32'h0, 0, 0, 1, 0);
    idle(1);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, ($urandom_range(0, 5) == 0), $urandom,
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
    end
    idle(1);

    sat_inc = 1'b1;
    repeat (14) @(negedge clk);
    #2;
    checkOutput("sat_14", sat_cnt, 4'd14);
    checkOutput("wrap_14", wrap_cnt, 4'd14);
    @(negedge clk); #2;
    checkOutput("sat_15", sat_cnt, 4'd15);
    checkOutput("wrap_15", wrap_cnt, 4'd15);
    @(negedge clk); #2;
    checkOutput("sat_hold", sat_cnt, 4'd15);
    checkOutput("wrap_0", wrap_cnt, 4'd0);
    @(negedge clk); #2;
    checkOutput("sat_hold2", sat_cnt, 4'd15);
    checkOutput("wrap_1", wrap_cnt, 4'd1);
    sat_inc = 1'b0;
    sat_clr = 1'b1;
    @(negedge clk); #2;
    checkOutput("sat_clear", sat_cnt, 4'd0);
    checkOutput("wrap_clear", wrap_cnt, 4'd0);
    sat_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
